// File: rtl/horner_seq.sv
// Horner-rule polynomial evaluator that issues load/opcode commands to the 16-bit accumulator ALU.
// Optional HORNER_CYCLE_COUNT_EN adds a saturating per-job cycle counter output.
`ifndef ALU_ADD
`define ALU_ADD 4'h0
`endif
`ifndef ALU_MUL
`define ALU_MUL 4'h2
`endif

module horner_seq #(
  parameter int         DATA_W     = 16,
  parameter int         MAX_DEGREE = 15,
  parameter int         DEG_W      = $clog2(MAX_DEGREE + 1),
  parameter logic [3:0] NOP_OPCODE = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] x,
  input  logic [DEG_W-1:0]  degree,
  output logic              busy,
  input  logic              coef_valid,
  input  logic [DATA_W-1:0] coef_data,
  output logic              coef_ready,
  output logic              alu_load,
  output logic [DATA_W-1:0] alu_in_val,
  output logic [3:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_out_val,
  output logic              result_valid,
  output logic [DATA_W-1:0] result,
  input  logic              result_ready
`ifdef HORNER_CYCLE_COUNT_EN
  ,
  output logic [15:0]       cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MUL, S_ADD, S_DRAIN1, S_DRAIN2, S_DONE
  } state_t;

  state_t            r_state;
  logic [DEG_W-1:0]  r_k;
  logic [DATA_W-1:0] r_x;
  logic              r_busy;
  logic              r_result_valid;
  logic [DATA_W-1:0] r_result;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_k            <= '0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_result       <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_LOAD;
          r_k     <= degree;
          r_busy  <= 1'b1;
        end
        S_LOAD: if (coef_valid) r_state <= (r_k != '0) ? S_MUL : S_DRAIN1;
        S_MUL:  r_state <= S_ADD;
        S_ADD: if (coef_valid) begin
          r_k     <= r_k - DEG_W'(1);
          r_state <= (r_k > DEG_W'(1)) ? S_MUL : S_DRAIN1;
        end
        S_DRAIN1: r_state <= S_DRAIN2;
        // ALU out_val trails the accumulator by one non-load cycle, so capture here.
        S_DRAIN2: begin
          r_result       <= alu_out_val;
          r_result_valid <= 1'b1;
          r_state        <= S_DONE;
        end
        S_DONE: if (result_ready) begin
          r_result_valid <= 1'b0;
          r_busy         <= 1'b0;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Evaluation point is pure data: no reset, only loaded on an accepted start.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && start) r_x <= x;
  end

  always_comb begin
    alu_load   = 1'b0;
    alu_in_val = '0;
    alu_opcode = NOP_OPCODE;
    case (r_state)
      S_LOAD: if (coef_valid) begin
        alu_load   = 1'b1;
        alu_in_val = coef_data;
      end
      S_MUL: begin
        alu_opcode = `ALU_MUL;
        alu_in_val = r_x;
      end
      S_ADD: if (coef_valid) begin
        alu_opcode = `ALU_ADD;
        alu_in_val = coef_data;
      end
      default: ;
    endcase
  end

  assign coef_ready   = (r_state == S_LOAD) || (r_state == S_ADD);
  assign busy         = r_busy;
  assign result_valid = r_result_valid;
  assign result       = r_result;

`ifdef HORNER_CYCLE_COUNT_EN
  logic [15:0] r_cycles;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycles <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_cycles <= '0;
    end else if (r_state inside {S_LOAD, S_MUL, S_ADD, S_DRAIN1, S_DRAIN2}) begin
      r_cycles <= sat_inc(r_cycles);
    end
  end

  assign cycles = r_cycles;
`endif

endmodule
